// File: rtl/dual_edge_detector_moore.sv
// rtl/dual_edge_detector_moore.sv - Moore FSM emitting a one-clock tick after every edge of level
// level must already be synchronous to clk; tick depends on state only.
module dual_edge_detector_moore (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    RISE = 2'b01,
    ONE  = 2'b10,
    FALL = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  always_comb begin
    state_next = ZERO;
    case (state)
      ZERO:    state_next = level ? RISE : ZERO;
      RISE:    state_next = level ? ONE  : FALL;
      ONE:     state_next = level ? ONE  : FALL;
      FALL:    state_next = level ? RISE : ZERO;
      default: state_next = ZERO;
    endcase
  end

  // tick is registered from the next state, so it always equals the decode of the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ZERO;
      tick  <= 1'b0;
    end else begin
      state <= state_next;
      tick  <= (state_next == RISE) || (state_next == FALL);
    end
  end

endmodule

// File: tb/tb_dual_edge_detector_moore.sv
// tb/tb_dual_edge_detector_moore.sv - directed bench for dual_edge_detector_moore
module tb_dual_edge_detector_moore;

  logic clk;
  logic reset;
  logic level;
  logic tick;

  int vectors;
  int miscompares;
  int tick_cnt;

  dual_edge_detector_moore dut (
    .clk   (clk),
    .reset (reset),
    .level (level),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic l, input logic exp, input string tag);
    reset = r;
    level = l;
    @(posedge clk);
    #1;
    vectors++;
    if (tick === 1'b1) tick_cnt++;
    assert (tick === exp)
      else begin
        miscompares++;
        $error("FAIL %s: tick=%b expected %b", tag, tick, exp);
      end
  endtask

  // apply level for four cycles; only the first may tick
  task automatic hold4(input logic l, input logic first_exp, input string tag);
    cyc(1'b0, l, first_exp, tag);
    for (int i = 0; i < 3; i++) cyc(1'b0, l, 1'b0, tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tick_cnt    = 0;
    reset       = 1'b1;
    level       = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, "reset_hold0");
    cyc(1'b1, 1'b0, 1'b0, "reset_hold1");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "after_release_low");

    hold4(1'b1, 1'b1, "rise");
    hold4(1'b0, 1'b1, "fall");
    hold4(1'b0, 1'b0, "no_edge_low");
    hold4(1'b1, 1'b1, "rise_again");
    hold4(1'b1, 1'b0, "no_edge_high");
    hold4(1'b0, 1'b1, "fall_again");

    tick_cnt = 0;
    hold4(1'b1, 1'b1, "seq0");
    hold4(1'b0, 1'b1, "seq1");
    hold4(1'b1, 1'b1, "seq2");
    hold4(1'b1, 1'b0, "seq3");
    hold4(1'b0, 1'b1, "seq4");
    hold4(1'b0, 1'b0, "seq5");
    hold4(1'b1, 1'b1, "seq6");
    hold4(1'b0, 1'b1, "seq7");
    vectors++;
    assert (tick_cnt == 6)
      else begin
        miscompares++;
        $error("FAIL seq_tick_count: got %0d expected 6", tick_cnt);
      end

    tick_cnt = 0;
    for (int i = 0; i < 6; i++) cyc(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, "toggle");
    cyc(1'b0, 1'b0, 1'b0, "toggle_end");
    vectors++;
    assert (tick_cnt == 6)
      else begin
        miscompares++;
        $error("FAIL toggle_tick_count: got %0d expected 6", tick_cnt);
      end

    cyc(1'b0, 1'b1, 1'b1, "pre_reset_tick");
    cyc(1'b1, 1'b1, 1'b0, "reset_mid_pulse");
    cyc(1'b1, 1'b1, 1'b0, "reset_held_high");
    cyc(1'b0, 1'b1, 1'b1, "release_high_tick");
    cyc(1'b0, 1'b1, 1'b0, "release_high_settle");

    cyc(1'b0, 1'b0, 1'b1, "fall_before_reset");
    cyc(1'b1, 1'b0, 1'b0, "reset_mid_fall");
    cyc(1'b0, 1'b0, 1'b0, "release_low_quiet");
    cyc(1'b0, 1'b0, 1'b0, "release_low_quiet2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
